// File: rtl/dsp_pkg.sv
// Shared constants for the DSP slice: OPMODE bit positions, default widths
// and the control bits that ride along with the MAC pipeline.
package dsp_pkg;

    localparam int OP_PREADD  = 0;
    localparam int OP_PRESUB  = 1;
    localparam int OP_ACC     = 2;
    localparam int OP_POSTSUB = 3;

    localparam int AW_DEF = 18;
    localparam int PW_DEF = 48;

    typedef struct packed {
        logic acc;
        logic postsub;
    } mac_ctl_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Enabled pipeline register with synchronous active-low clear; one instance per stage field.
module dsp_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mac_stage.sv
// Pre-add / multiply / post-add-accumulate pipeline of the DSP slice.
// All three stages advance together under a single valid/ready handshake.
module dsp_mac_stage
    import dsp_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int PW         = PW_DEF,
    parameter int USE_PREADD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [AW-1:0] d,
    input  logic [PW-1:0] c,
    input  logic [3:0]    opmode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p,
    output logic          carry_out,
    output logic          ovf,
    input  logic          clr_ovf
);

    logic                   adv;
    logic                   load3;

    logic                   v1_d, v1_q;
    logic [AW-1:0]          a1_d, a1_q;
    logic [AW-1:0]          pre1_d, pre1_q;
    logic [PW-1:0]          c1_d, c1_q;
    mac_ctl_t               ctl1_d, ctl1_q;

    logic                   v2_d, v2_q;
    logic [PW-1:0]          m2_d, m2_q;
    logic [PW-1:0]          c2_d, c2_q;
    mac_ctl_t               ctl2_d, ctl2_q;

    logic                   v3_d, v3_q;
    logic [PW-1:0]          p_d, p_q;
    logic                   carry_d, carry_q;
    logic                   ovf_d, ovf_q;

    logic signed [2*AW-1:0] a_ext, pre_ext, prod;
    logic [PW-1:0]          z, y;
    logic [PW:0]            sum;
    logic                   ovf_new;

    always_comb begin
        adv    = out_ready | ~v3_q;
        load3  = adv & v2_q;

        v1_d   = in_valid;
        a1_d   = a;
        c1_d   = c;
        ctl1_d = '{acc: opmode[OP_ACC], postsub: opmode[OP_POSTSUB]};
        pre1_d = b;
        if (USE_PREADD != 0 && opmode[OP_PREADD]) begin
            pre1_d = opmode[OP_PRESUB] ? (d - b) : (d + b);
        end

        v2_d    = v1_q;
        c2_d    = c1_q;
        ctl2_d  = ctl1_q;
        a_ext   = (2*AW)'($signed(a1_q));
        pre_ext = (2*AW)'($signed(pre1_q));
        prod    = a_ext * pre_ext;
        m2_d    = PW'(prod);

        // Subtraction is Z + ~M + 1, so the carry out is the inverted borrow.
        v3_d    = v2_q;
        z       = ctl2_q.acc ? p_q : c2_q;
        y       = ctl2_q.postsub ? ~m2_q : m2_q;
        sum     = {1'b0, z} + {1'b0, y} + {{PW{1'b0}}, ctl2_q.postsub};
        p_d     = sum[PW-1:0];
        carry_d = sum[PW];
        ovf_new = (z[PW-1] == y[PW-1]) && (p_d[PW-1] != z[PW-1]);
        ovf_d   = (load3 & ovf_new) | (ovf_q & ~clr_ovf);
    end

    dsp_pipe_reg #(.WIDTH(1))                u_v1   (.clk(clk), .rst(rst), .en(adv), .d(v1_d),   .q(v1_q));
    dsp_pipe_reg #(.WIDTH(AW))               u_a1   (.clk(clk), .rst(rst), .en(adv), .d(a1_d),   .q(a1_q));
    dsp_pipe_reg #(.WIDTH(AW))               u_pre1 (.clk(clk), .rst(rst), .en(adv), .d(pre1_d), .q(pre1_q));
    dsp_pipe_reg #(.WIDTH(PW))               u_c1   (.clk(clk), .rst(rst), .en(adv), .d(c1_d),   .q(c1_q));
    dsp_pipe_reg #(.WIDTH($bits(mac_ctl_t))) u_ctl1 (.clk(clk), .rst(rst), .en(adv), .d(ctl1_d), .q(ctl1_q));

    dsp_pipe_reg #(.WIDTH(1))                u_v2   (.clk(clk), .rst(rst), .en(adv), .d(v2_d),   .q(v2_q));
    dsp_pipe_reg #(.WIDTH(PW))               u_m2   (.clk(clk), .rst(rst), .en(adv), .d(m2_d),   .q(m2_q));
    dsp_pipe_reg #(.WIDTH(PW))               u_c2   (.clk(clk), .rst(rst), .en(adv), .d(c2_d),   .q(c2_q));
    dsp_pipe_reg #(.WIDTH($bits(mac_ctl_t))) u_ctl2 (.clk(clk), .rst(rst), .en(adv), .d(ctl2_d), .q(ctl2_q));

    // Result registers only load on real beats, so bubbles leave p and carry untouched.
    dsp_pipe_reg #(.WIDTH(1))                u_v3   (.clk(clk), .rst(rst), .en(adv),   .d(v3_d),    .q(v3_q));
    dsp_pipe_reg #(.WIDTH(PW))               u_p    (.clk(clk), .rst(rst), .en(load3), .d(p_d),     .q(p_q));
    dsp_pipe_reg #(.WIDTH(1))                u_cy   (.clk(clk), .rst(rst), .en(load3), .d(carry_d), .q(carry_q));
    dsp_pipe_reg #(.WIDTH(1))                u_ovf  (.clk(clk), .rst(rst), .en(1'b1),  .d(ovf_d),   .q(ovf_q));

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign p         = p_q;
    assign carry_out = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_stage.sv
// Directed, table-driven bench for dsp_mac_stage with hand-written sequences
// for latency, accumulate chaining, backpressure, sticky overflow and reset.
module tb_dsp_mac_stage;

    localparam int AW = 18;
    localparam int PW = 48;

    typedef struct {
        logic [3:0]              opmode;
        logic signed [AW-1:0]    a;
        logic signed [AW-1:0]    b;
        logic signed [AW-1:0]    d;
        logic signed [PW-1:0]    c;
        logic signed [PW-1:0]    exp_p;
        logic                    exp_carry;
        logic                    exp_ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a, b, d;
    logic [PW-1:0] c;
    logic [3:0]    opmode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p;
    logic          carry_out;
    logic          ovf;
    logic          clr_ovf;

    int compared = 0;
    int failed   = 0;
    bit mon_en   = 1'b0;

    vec_t                 vecs [12];
    vec_t                 beat_q [$];
    logic signed [PW-1:0] exp_q [$];

    dsp_mac_stage #(.AW(AW), .PW(PW), .USE_PREADD(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .d(d), .c(c), .opmode(opmode),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .carry_out(carry_out), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic signed [PW-1:0] act, input logic signed [PW-1:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        opmode = v.opmode;
        a      = v.a;
        b      = v.b;
        d      = v.d;
        c      = v.c;
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    // Stream monitor: every accepted output must match the next expected value in order.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL stream_extra: got p=%0d, expected no output", $signed(p));
            end else begin
                check("stream_p", p, exp_q.pop_front());
            end
        end
    end

    task automatic run_stream(input int stall_lo, input int stall_hi, input string tag);
        int cyc = 0;
        mon_en = 1'b1;
        while (cyc < 60 && (beat_q.size() > 0 || exp_q.size() > 0)) begin
            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
            if (beat_q.size() > 0) begin
                drive(beat_q[0]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && !out_ready) check({tag, "_in_ready_stalled"}, in_ready, 0);
            if (in_valid && in_ready) void'(beat_q.pop_front());
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_left_over"}, exp_q.size() + beat_q.size(), 0);
        mon_en = 1'b0;
        beat_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        bit   seen;

        vecs[0]  = '{4'b0000, 18'sd3,     18'sd5,     18'sd0,      48'sd7,   48'sd22,          1'b0, 1'b0};
        vecs[1]  = '{4'b1011, -18'sd2,    18'sd4,     18'sd10,     48'sd100, 48'sd112,         1'b0, 1'b0};
        vecs[2]  = '{4'b0001, 18'sd3,     18'sd4,     18'sd10,     48'sd0,   48'sd42,          1'b0, 1'b0};
        vecs[3]  = '{4'b0011, 18'sd3,     18'sd4,     18'sd10,     48'sd5,   48'sd23,          1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 18'sd3,     18'sd5,     18'sd0,      48'sd7,   -48'sd8,          1'b0, 1'b0};
        vecs[5]  = '{4'b1000, 18'sd2,     18'sd3,     18'sd0,      48'sd10,  48'sd4,           1'b1, 1'b0};
        vecs[6]  = '{4'b0000, -18'sd1,    18'sd1,     18'sd0,      48'sd5,   48'sd4,           1'b1, 1'b0};
        vecs[7]  = '{4'b0001, 18'sd1,     18'sd1,     18'sd131071, 48'sd0,   -48'sd131072,     1'b0, 1'b0};
        vecs[8]  = '{4'b0011, 18'sd2,     18'sd1,     18'sh20000,  48'sd0,   48'sd262142,      1'b0, 1'b0};
        vecs[9]  = '{4'b0000, 18'sh20000, 18'sh20000, 18'sd0,      48'sd0,   48'sd17179869184, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 18'sd1,     18'sd1,     18'sd0,      48'sh8000_0000_0000, 48'sh7FFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[11] = '{4'b0000, 18'sd1,     18'sd1,     18'sd0,      48'sh7FFF_FFFF_FFFF, 48'sh8000_0000_0000, 1'b0, 1'b1};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        a = '0; b = '0; d = '0; c = '0; opmode = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_p", p, 0);
        check("reset_carry", carry_out, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);
        tick();

        // Latency: three accepted cycles, single-cycle out_valid pulse, p holds afterwards.
        drive(vecs[0]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk); check("lat_cycle1_valid", out_valid, 0);
        tick();
        @(negedge clk); check("lat_cycle2_valid", out_valid, 0);
        tick();
        @(negedge clk); check("lat_cycle3_valid", out_valid, 1);
        check("lat_p", p, 22);
        check("lat_ovf", ovf, 0);
        check("lat_carry", carry_out, 0);
        tick();
        @(negedge clk); check("lat_pulse_end", out_valid, 0);
        check("lat_p_hold", p, 22);
        tick();

        for (int i = 0; i < 12; i++) begin
            clear_ovf();
            drive(vecs[i]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int w = 0; w < 8; w++) begin
                @(negedge clk);
                if (out_valid) break;
                tick();
            end
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d_carry", i), carry_out, vecs[i].exp_carry);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            tick();
        end
        clear_ovf();

        // Accumulate chain: back-to-back beats fold in the previous p every cycle.
        v = '{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sd0, 48'sd1, 1'b0, 1'b0};
        beat_q.push_back(v); exp_q.push_back(48'sd1);
        for (int k = 0; k < 4; k++) begin
            v = '{4'b0100, 18'sd2, 18'sd3, 18'sd0, 48'sd999, 48'sd0, 1'b0, 1'b0};
            beat_q.push_back(v);
            exp_q.push_back(48'(7 + 6 * k));
        end
        run_stream(100, 100, "acc");

        // Backpressure: out_ready low for four cycles while results are waiting.
        for (int k = 0; k < 6; k++) begin
            v = '{4'b0000, 18'(k + 1), 18'sd2, 18'sd0, 48'(100 * k), 48'sd0, 1'b0, 1'b0};
            beat_q.push_back(v);
            exp_q.push_back(48'(100 * k + 2 * (k + 1)));
        end
        run_stream(4, 8, "bp");

        // Sticky overflow, explicit clear, and set winning over a same-cycle clear.
        v = '{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 48'sd0, 1'b0, 1'b0};
        beat_q.push_back(v); exp_q.push_back(48'sh8000_0000_0000);
        run_stream(100, 100, "ovf1");
        @(negedge clk); check("ovf_set", ovf, 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            v = '{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sd0, 48'sd0, 1'b0, 1'b0};
            beat_q.push_back(v); exp_q.push_back(48'sd1);
        end
        run_stream(100, 100, "ovf2");
        @(negedge clk); check("ovf_sticky", ovf, 1);
        tick();
        clear_ovf();
        @(negedge clk); check("ovf_cleared", ovf, 0);
        tick();
        drive('{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 48'sd0, 1'b0, 1'b0});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_set_wins_valid", out_valid, 1);
        check("ovf_set_wins", ovf, 1);
        check("ovf_set_wins_p", p, 48'sh8000_0000_0000);
        tick();
        clear_ovf();

        // Reset with all three stages holding valid data under backpressure.
        out_ready = 1'b0;
        drive('{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 48'sd0, 1'b0, 1'b0});
        in_valid = 1'b1;
        tick();
        drive('{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sd5, 48'sd0, 1'b0, 1'b0});
        tick();
        drive('{4'b0000, 18'sd1, 18'sd1, 18'sd0, 48'sd6, 48'sd0, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ovf", ovf, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("rst_no_stale", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
